// File: rtl/servo_slew_ctrl_if.sv
// Command/angle bundle between the SPI frame latch, the slew stage and the PWM stage.
// cmd_valid is a single-cycle strobe with no ready: the slew stage always accepts a frame.
interface servo_slew_ctrl_if;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic [7:0]  angle_x;
  logic [7:0]  angle_y;
  logic        update_tick;
  logic        at_target;
  logic        timeout;
  logic [7:0]  target_x;
  logic [7:0]  target_y;

  modport master (
    output cmd_valid, cmd_data,
    input  angle_x, angle_y, update_tick, at_target, timeout, target_x, target_y
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output angle_x, angle_y, update_tick, at_target, timeout, target_x, target_y
  );
endinterface

// File: rtl/servo_slew_ctrl.sv
// Slew-rate limited X/Y servo command stage with a frame watchdog that recentres
// both axes when the command stream goes quiet.
module servo_slew_ctrl #(
  parameter int UPDATE_DIV    = 120000,
  parameter int MAX_STEP      = 4,
  parameter int CENTER        = 128,
  parameter int TIMEOUT_TICKS = 200
) (
  input logic              CLK,
  input logic              rst,
  servo_slew_ctrl_if.slave bus
);

  localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(UPDATE_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_TICKS);
  localparam logic [WD_W-1:0]  WD_EXPIRE = WD_W'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]       CENTER_V  = 8'(CENTER);
  // Steps of 255 or more all behave as "jump straight to target".
  localparam int               STEP_CLAMP = (MAX_STEP > 255) ? 255 : MAX_STEP;
  localparam logic [8:0]       STEP9      = 9'(STEP_CLAMP);
  localparam logic [7:0]       STEP8      = 8'(STEP_CLAMP);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       angle_x_q, angle_x_d;
  logic [7:0]       angle_y_q, angle_y_d;
  logic [7:0]       target_x_q, target_x_d;
  logic [7:0]       target_y_q, target_y_d;

  function automatic logic [7:0] step_toward(input logic [7:0] angle, input logic [7:0] target);
    logic signed [8:0] diff;
    logic [8:0]        mag;
    diff = $signed({1'b0, target}) - $signed({1'b0, angle});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= STEP9) begin
      return target;
    end else if (diff[8]) begin
      return angle - STEP8;
    end else begin
      return angle + STEP8;
    end
  endfunction

  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d     = (div_q == DIV_LAST);
    wd_d       = wd_q;
    timeout_d  = timeout_q;
    angle_x_d  = angle_x_q;
    angle_y_d  = angle_y_q;
    target_x_d = target_x_q;
    target_y_d = target_y_q;

    // Stepping sees the targets as they were before this edge.
    if (tick_q) begin
      angle_x_d = step_toward(angle_x_q, target_x_q);
      angle_y_d = step_toward(angle_y_q, target_y_q);
    end

    if (bus.cmd_valid) begin
      target_x_d = bus.cmd_data[15:8];
      target_y_d = bus.cmd_data[7:0];
      wd_d       = '0;
      timeout_d  = 1'b0;
    end else if (tick_q && (wd_q != WD_LIMIT)) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WD_EXPIRE) begin
        timeout_d  = 1'b1;
        target_x_d = CENTER_V;
        target_y_d = CENTER_V;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      angle_x_q  <= CENTER_V;
      angle_y_q  <= CENTER_V;
      target_x_q <= CENTER_V;
      target_y_q <= CENTER_V;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      angle_x_q  <= angle_x_d;
      angle_y_q  <= angle_y_d;
      target_x_q <= target_x_d;
      target_y_q <= target_y_d;
    end
  end

  assign bus.angle_x     = angle_x_q;
  assign bus.angle_y     = angle_y_q;
  assign bus.update_tick = tick_q;
  assign bus.timeout     = timeout_q;
  assign bus.at_target   = (angle_x_q == target_x_q) && (angle_y_q == target_y_q);
  assign bus.target_x    = target_x_q;
  assign bus.target_y    = target_y_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl: directed scenarios plus random frames/resets, every cycle
// compared against an arithmetic model of the slew and watchdog rules.
module tb_servo_slew_ctrl;
  localparam int DIV      = 10;
  localparam int STEP     = 4;
  localparam int CTR      = 128;
  localparam int TO_TICKS = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  servo_slew_ctrl_if bus();

  servo_slew_ctrl #(
    .UPDATE_DIV(DIV), .MAX_STEP(STEP), .CENTER(CTR), .TIMEOUT_TICKS(TO_TICKS)
  ) dut (
    .CLK(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #2ms;
    $display("FAIL sim_time_limit got=expired exp=finish");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ax, m_ay, m_tx, m_ty, m_wd, m_cyc;
  bit m_tick, m_to;
  bit m_valid = 1'b0;
  bit last_tick_seen;

  function automatic int toward(input int a, input int t);
    if (t > a) return (t - a > STEP) ? a + STEP : t;
    if (a > t) return (a - t > STEP) ? a - STEP : t;
    return a;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [15:0] d);
    bit tk;
    tk = m_tick;
    if (r) begin
      m_ax = CTR; m_ay = CTR; m_tx = CTR; m_ty = CTR;
      m_wd = 0; m_to = 0; m_cyc = 0; m_tick = 0; m_valid = 1;
      return;
    end
    if (tk) begin
      m_ax = toward(m_ax, m_tx);
      m_ay = toward(m_ay, m_ty);
    end
    if (v) begin
      m_tx = int'(d[15:8]); m_ty = int'(d[7:0]); m_wd = 0; m_to = 0;
    end else if (tk && m_wd < TO_TICKS) begin
      m_wd++;
      if (m_wd == TO_TICKS) begin
        m_to = 1; m_tx = CTR; m_ty = CTR;
      end
    end
    m_cyc++;
    m_tick = (m_cyc % DIV) == 0;
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic r, input logic v, input logic [15:0] d);
    @(negedge clk);
    if (m_valid) begin
      check_eq("angle_x", bus.angle_x, m_ax);
      check_eq("angle_y", bus.angle_y, m_ay);
      check_eq("target_x", bus.target_x, m_tx);
      check_eq("target_y", bus.target_y, m_ty);
      check_eq("update_tick", bus.update_tick, m_tick);
      check_eq("timeout", bus.timeout, m_to);
      check_eq("at_target", bus.at_target, (m_ax == m_tx) && (m_ay == m_ty));
    end
    last_tick_seen = bus.update_tick;
    rst           = r;
    bus.cmd_valid = v;
    bus.cmd_data  = d;
    @(posedge clk);
    model_edge(r, v, d);
  endtask

  task automatic measure_first_tick(input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      do_cycle(1'b0, 1'b0, 16'h0);
      #1;
      if (bus.update_tick && first < 0) first = k;
    end
    check_eq(tag, first, DIV);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 16'h0);
  endtask

  task automatic wait_model_tick();
    for (int i = 0; i < 2 * DIV && !m_tick; i++) do_cycle(1'b0, 1'b0, 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int steps, done, n;
    logic v, r;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'h0;

    // Scenario 1: reset held 3 cycles mid-count
    do_cycle(1'b1, 1'b0, 16'h0);
    do_cycle(1'b1, 1'b0, 16'h0);
    run_idle(14);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 16'h1234);
    #1;
    check_eq("rst_angle_x", bus.angle_x, CTR);
    check_eq("rst_angle_y", bus.angle_y, CTR);
    check_eq("rst_at_target", bus.at_target, 1);
    check_eq("rst_timeout", bus.timeout, 0);
    check_eq("rst_drops_cmd", bus.target_x, CTR);
    measure_first_tick("first_tick_latency");

    // Scenario 2: full-range ramp in both directions
    do_cycle(1'b0, 1'b1, 16'hFF00);
    steps = 0;
    done  = -1;
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'b0, 1'b0, 16'h0);
      if (last_tick_seen) steps++;
      #1;
      if (bus.at_target && done < 0) done = steps;
    end
    check_eq("ramp_ticks", done, 32);
    check_eq("ramp_x_end", bus.angle_x, 255);
    check_eq("ramp_y_end", bus.angle_y, 0);

    // Scenario 3: partial step smaller than MAX_STEP
    do_cycle(1'b1, 1'b0, 16'h0);
    do_cycle(1'b0, 1'b1, 16'h8280);
    run_idle(12);
    #1;
    check_eq("partial_x", bus.angle_x, 130);
    check_eq("partial_y", bus.angle_y, 128);
    check_eq("partial_at_target", bus.at_target, 1);

    // Scenario 5: command landing on a tick steps toward the old target first
    do_cycle(1'b1, 1'b0, 16'h0);
    do_cycle(1'b0, 1'b1, 16'hA0A0);
    wait_model_tick();
    do_cycle(1'b0, 1'b1, 16'h6060);
    #1;
    check_eq("coincide_old_target", bus.angle_x, 132);
    wait_model_tick();
    do_cycle(1'b0, 1'b0, 16'h0);
    #1;
    check_eq("coincide_new_target", bus.angle_x, 128);

    // Scenario 6: reset mid-ramp
    do_cycle(1'b1, 1'b0, 16'h0);
    do_cycle(1'b0, 1'b1, 16'hFF80);
    for (int i = 0; i < 400 && m_ax < 200; i++) do_cycle(1'b0, 1'b0, 16'h0);
    do_cycle(1'b1, 1'b0, 16'h0);
    #1;
    check_eq("midramp_rst_angle_x", bus.angle_x, CTR);
    check_eq("midramp_rst_target_x", bus.target_x, CTR);
    measure_first_tick("midramp_rst_divider");

    // Scenario 4: watchdog expiry and recentring
    do_cycle(1'b0, 1'b1, 16'hFFFF);
    run_idle(TO_TICKS * DIV + 10);
    #1;
    check_eq("wd_timeout_set", bus.timeout, 1);
    run_idle(400);
    #1;
    check_eq("wd_recenter_x", bus.angle_x, CTR);
    check_eq("wd_recenter_y", bus.angle_y, CTR);
    do_cycle(1'b0, 1'b1, 16'h4050);
    #1;
    check_eq("wd_cmd_clears", bus.timeout, 0);

    // Scenario 4b: command on the expiring tick wins
    n = 0;
    for (int i = 0; i < 3000 && n < TO_TICKS - 1; i++) begin
      if (m_tick) n++;
      do_cycle(1'b0, 1'b0, 16'h0);
    end
    wait_model_tick();
    do_cycle(1'b0, 1'b1, 16'h1234);
    #1;
    check_eq("wd_race_timeout", bus.timeout, 0);
    check_eq("wd_race_target_x", bus.target_x, 8'h12);
    check_eq("wd_race_target_y", bus.target_y, 8'h34);

    // Random: busy command stream with occasional resets
    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 1499) == 0);
      v = m_tick ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      do_cycle(r, v, 16'($urandom));
    end
    // Random: sparse frames so the watchdog expires
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 2499) == 0);
      do_cycle(1'b0, v, 16'($urandom));
    end
    do_cycle(1'b0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
